batt_mon: RTL and testbench

- Upstream neighbour of the piezo driver. Periodically requests a battery conversion from the A2D interface and averages the last 4 samples.
- Applies threshold hysteresis plus N-sample confirmation, then drives a clean, level `batt_low` flag. The piezo driver edge-detects that flag to play its low-battery tune.
- Also exports the averaged reading for status and telemetry.

---
 rtl/batt_mon_pkg.sv | 31 +++
 rtl/batt_avg4.sv | 42 ++++
 rtl/batt_mon.sv | 107 ++++++++++
 tb/tb_batt_mon.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/batt_mon_pkg.sv
// Shared types and constants for the battery monitor and its A2D neighbours.
// Thresholds live here so the top level and the channel logic agree on them.
package batt_mon_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    REQ  = 2'd1,
    CONV = 2'd2,
    EVAL = 2'd3
  } bm_state_t;

  localparam int unsigned PERIOD_W_FAST = 12;
  localparam int unsigned PERIOD_W_SLOW = 20;

  localparam logic [9:0] CONV_TIMEOUT = 10'd1023;

  localparam logic [11:0] DEF_LOW_THRESH  = 12'hC80;
  localparam logic [11:0] DEF_HIGH_THRESH = 12'hD00;
  localparam int unsigned DEF_CONFIRM     = 3;

  // 14-bit sum cannot overflow for four full-scale readings; shift truncates.
  function automatic logic [11:0] avg4(input logic [11:0] a,
                                       input logic [11:0] b,
                                       input logic [11:0] c,
                                       input logic [11:0] d);
    logic [13:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return sum[13:2];
  endfunction

endpackage

// File: rtl/batt_avg4.sv
// Four-entry sliding window of battery readings with a registered average.
// Entries start at full scale so early averages never look low.
module batt_avg4
  import batt_mon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] din,
  output logic [11:0] avg
);

  logic [11:0] win_q [4];
  logic [11:0] win_d [4];
  logic [11:0] avg_q;
  logic [11:0] avg_d;

  always_comb begin
    win_d = win_q;
    avg_d = avg_q;
    if (load) begin
      win_d[0] = din;
      win_d[1] = win_q[0];
      win_d[2] = win_q[1];
      win_d[3] = win_q[2];
      avg_d    = avg4(din, win_q[0], win_q[1], win_q[2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) win_q[i] <= 12'hFFF;
      avg_q <= 12'hFFF;
    end else begin
      win_q <= win_d;
      avg_q <= avg_d;
    end
  end

  assign avg = avg_q;

endmodule

// File: rtl/batt_mon.sv
// Battery monitor: periodic A2D requests, 4-sample averaging, and a
// hysteresis + N-sample confirmed low-battery level flag.
module batt_mon
  import batt_mon_pkg::*;
#(
  parameter bit          FAST_SIM    = 1'b1,
  parameter logic [11:0] LOW_THRESH  = DEF_LOW_THRESH,
  parameter logic [11:0] HIGH_THRESH = DEF_HIGH_THRESH,
  parameter int unsigned CONFIRM     = DEF_CONFIRM
)(
  input  logic        clk,
  input  logic        rst_n,
  output logic        strt_cnv,
  input  logic        cnv_cmplt,
  input  logic [11:0] batt_res,
  output logic [11:0] batt_avg,
  output logic        batt_low
);

  localparam int unsigned PW        = FAST_SIM ? PERIOD_W_FAST : PERIOD_W_SLOW;
  localparam logic [2:0]  CONFIRM_C = 3'(CONFIRM);

  bm_state_t     state_q, state_d;
  logic [PW-1:0] timer_q, timer_d;
  logic [9:0]    to_q, to_d;
  logic [2:0]    low_streak_q, low_streak_d;
  logic [2:0]    good_streak_q, good_streak_d;
  logic          batt_low_q, batt_low_d;
  logic          avg_load;

  batt_avg4 u_avg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (avg_load),
    .din   (batt_res),
    .avg   (batt_avg)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = '0;
    to_d          = to_q;
    low_streak_d  = low_streak_q;
    good_streak_d = good_streak_q;
    batt_low_d    = batt_low_q;
    avg_load      = 1'b0;
    case (state_q)
      WAIT: begin
        // All-ones terminal count wraps the timer back to zero on its own.
        timer_d = timer_q + 1'b1;
        if (&timer_q) state_d = REQ;
      end
      REQ: begin
        to_d    = '0;
        state_d = CONV;
      end
      CONV: begin
        if (cnv_cmplt) begin
          avg_load = 1'b1;
          state_d  = EVAL;
        end else if (to_q == CONV_TIMEOUT) begin
          state_d = WAIT;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      EVAL: begin
        if (batt_avg < LOW_THRESH) begin
          low_streak_d  = (low_streak_q == CONFIRM_C) ? low_streak_q : low_streak_q + 1'b1;
          good_streak_d = '0;
        end else if (batt_avg >= HIGH_THRESH) begin
          good_streak_d = (good_streak_q == CONFIRM_C) ? good_streak_q : good_streak_q + 1'b1;
          low_streak_d  = '0;
        end else begin
          low_streak_d  = '0;
          good_streak_d = '0;
        end
        if (low_streak_d == CONFIRM_C) batt_low_d = 1'b1;
        else if (good_streak_d == CONFIRM_C) batt_low_d = 1'b0;
        state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT;
      timer_q       <= '0;
      to_q          <= '0;
      low_streak_q  <= '0;
      good_streak_q <= '0;
      batt_low_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      to_q          <= to_d;
      low_streak_q  <= low_streak_d;
      good_streak_q <= good_streak_d;
      batt_low_q    <= batt_low_d;
    end
  end

  assign strt_cnv = (state_q == REQ);
  assign batt_low = batt_low_q;

endmodule

// File: tb/tb_batt_mon.sv
// Directed bench for batt_mon: one conversion slot per table row, with
// hand-computed averages/flags, plus a reset-during-conversion sequence.
module tb_batt_mon;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strt_cnv;
  logic        cnv_cmplt;
  logic [11:0] batt_res;
  logic [11:0] batt_avg;
  logic        batt_low;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  batt_mon #(.FAST_SIM(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .cnv_cmplt (cnv_cmplt),
    .batt_res  (batt_res),
    .batt_avg  (batt_avg),
    .batt_low  (batt_low)
  );

  // delay = CONV cycles before cnv_cmplt; 1024 means no answer in time.
  typedef struct {
    logic [11:0] res;
    int          delay;
    bit          spur;
    logic [11:0] expAvg;
    logic        expLow;
  } vec_t;

  vec_t        vecs [16];
  int          prevReqCyc;
  int          expSpacing;
  logic [11:0] curAvg;
  logic        curLow;
  bit          aborted = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitReq(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk); #1;
      if (strt_cnv) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      aborted = 1'b1;
      $display("[TB] FAIL req timeout: strt_cnv=0 after 6000 cycles, required 1");
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    bit seen;
    if (v.spur) begin
      batt_res  = 12'h000;
      cnv_cmplt = 1'b1;
      @(posedge clk); #1;
      cnv_cmplt = 1'b0;
    end
    waitReq(seen);
    if (!seen) return;
    checkOutput($sformatf("v%0d req spacing", idx), cyc - prevReqCyc, expSpacing);
    prevReqCyc = cyc;
    if (v.spur) begin
      batt_res  = 12'h000;
      cnv_cmplt = 1'b1;
    end
    @(posedge clk); #1;
    cnv_cmplt = 1'b0;
    checkOutput($sformatf("v%0d strt width", idx), strt_cnv, 0);
    checkOutput($sformatf("v%0d avg held", idx), batt_avg, curAvg);
    for (int k = 0; k < v.delay; k++) begin
      @(posedge clk); #1;
    end
    batt_res  = v.res;
    cnv_cmplt = 1'b1;
    @(posedge clk); #1;
    cnv_cmplt = 1'b0;
    if (v.delay < 1024) begin
      checkOutput($sformatf("v%0d avg t+1", idx), batt_avg, v.expAvg);
      checkOutput($sformatf("v%0d low t+1", idx), batt_low, curLow);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d low t+2", idx), batt_low, v.expLow);
      expSpacing = 4099 + v.delay;
    end else begin
      checkOutput($sformatf("v%0d avg after timeout", idx), batt_avg, v.expAvg);
      checkOutput($sformatf("v%0d low after timeout", idx), batt_low, v.expLow);
      expSpacing = 5121;
    end
    curAvg = v.expAvg;
    curLow = v.expLow;
  endtask

  task automatic resetMidConversion();
    bit seen;
    waitReq(seen);
    if (!seen) return;
    checkOutput("rst req spacing", cyc - prevReqCyc, expSpacing);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst low before", batt_low, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst low async", batt_low, 0);
    checkOutput("rst avg async", batt_avg, 12'hFFF);
    checkOutput("rst strt async", strt_cnv, 0);
    @(posedge clk); #1;
    rst_n      = 1'b1;
    batt_res   = 12'h000;
    cnv_cmplt  = 1'b1;
    prevReqCyc = cyc;
    @(posedge clk); #1;
    cnv_cmplt = 1'b0;
    checkOutput("rst late cmplt avg", batt_avg, 12'hFFF);
    @(posedge clk); #1;
    checkOutput("rst late cmplt avg2", batt_avg, 12'hFFF);
    checkOutput("rst late cmplt low", batt_low, 0);
    waitReq(seen);
    if (!seen) return;
    checkOutput("rst next req spacing", cyc - prevReqCyc, 4096);
  endtask

  initial begin
    vecs[0]  = '{12'hA00, 0,    1'b0, 12'hE7F, 1'b0};
    vecs[1]  = '{12'hA00, 2,    1'b0, 12'hCFF, 1'b0};
    vecs[2]  = '{12'hA00, 0,    1'b0, 12'hB7F, 1'b0};
    vecs[3]  = '{12'hA00, 5,    1'b0, 12'hA00, 1'b0};
    vecs[4]  = '{12'hA00, 0,    1'b0, 12'hA00, 1'b1};
    vecs[5]  = '{12'hE00, 0,    1'b1, 12'hB00, 1'b1};
    vecs[6]  = '{12'hE00, 0,    1'b0, 12'hC00, 1'b1};
    vecs[7]  = '{12'h000, 1024, 1'b0, 12'hC00, 1'b1};
    vecs[8]  = '{12'hE00, 0,    1'b0, 12'hD00, 1'b1};
    vecs[9]  = '{12'hE00, 1023, 1'b0, 12'hE00, 1'b1};
    vecs[10] = '{12'hE00, 0,    1'b0, 12'hE00, 1'b0};
    vecs[11] = '{12'h700, 0,    1'b0, 12'hC40, 1'b0};
    vecs[12] = '{12'hF00, 0,    1'b1, 12'hC80, 1'b0};
    vecs[13] = '{12'hD00, 3,    1'b0, 12'hC40, 1'b0};
    vecs[14] = '{12'h000, 0,    1'b0, 12'h8C0, 1'b0};
    vecs[15] = '{12'h000, 0,    1'b0, 12'h700, 1'b1};

    rst_n     = 1'b0;
    cnv_cmplt = 1'b0;
    batt_res  = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset strt_cnv", strt_cnv, 0);
    checkOutput("reset batt_avg", batt_avg, 12'hFFF);
    checkOutput("reset batt_low", batt_low, 0);
    rst_n      = 1'b1;
    prevReqCyc = cyc;
    expSpacing = 4096;
    curAvg     = 12'hFFF;
    curLow     = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (!aborted) applyStimulus(vecs[i], i);
    end
    if (!aborted) resetMidConversion();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
